box_track_ctrl: RTL and testbench
=================================

// Module: box_track_ctrl
// PURPOSE
//  Frame-level scheduler behind the box detector. Once per frame it validates the latched box edges.
//  It runs a hysteresis FSM: IDLE -> TRACK, with COAST between TRACK and IDLE.
//  It pushes overlay configuration (enable + 4 edges) to the drawing block over a valid/ready handshake.
//  Updates are issued only at frame boundaries, so the overlay never tears mid-frame.
// PARAMETERS
//  ACQ_FRAMES    3   consecutive valid frames needed to enter TRACK (1..15)
//  LOST_FRAMES   4   consecutive invalid frames in COAST before dropping to IDLE (1..15)
//  MIN_SIZE      8   minimum box width and height in pixels for a hit
//  SMOOTH_SHIFT  2   IIR shift; used only when BOX_SMOOTH_EN is defined
// PORTS
//  clk           in   1   pixel clock
//  rst_n         in   1   reset, asynchronous, active-low
//  frame_done    in   1   1-cycle pulse: box_flag/edges below are valid this cycle
//  box_flag      in   1   detector saw at least one foreground pixel
//  top_edge      in   11  box top row
//  bottom_edge   in   11  box bottom row
//  left_edge     in   11  box left column
//  right_edge    in   11  box right column
//  ovl_valid     out  1   overlay update pending
//  ovl_ready     in   1   drawing block accepts the update
//  ovl_en        out  1   draw box (payload)
//  ovl_top, ovl_bottom, ovl_left, ovl_right  out  11  edges (payload)
//  track_state   out  2   0=IDLE 1=TRACK 2=COAST
//  lost_pulse    out  1   1-cycle pulse on the COAST->IDLE transition
//  overrun_cnt   out  8   saturating count of shadow-slot overwrites
// BEHAVIOUR
//  Reset: all outputs and internal registers are 0; state is IDLE.
//  Reset mid-operation aborts any pending handshake immediately (ovl_valid drops to 0).
//  Sampling at T: edges are captured on the frame_done cycle T. A frame_done during reset is ignored.
//  Evaluation at T+1: hit = box_flag & bottom>=top & right>=left & (bottom-top+1)>=MIN_SIZE & (right-left+1)>=MIN_SIZE.
//   Size arithmetic is unsigned 12-bit, so the +1 cannot wrap.
//  FSM transitions are evaluated at T+1:
//   IDLE:  hit -> hit_cnt++. When hit_cnt reaches ACQ_FRAMES: go to TRACK, clear hit_cnt, queue update with en=1.
//          miss -> hit_cnt=0.
//   TRACK: hit -> stay, queue update with en=1.
//          miss -> go to COAST, miss_cnt=1; no update, overlay keeps the last box.
//   COAST: hit -> go to TRACK, miss_cnt=0, queue update with en=1.
//          miss -> miss_cnt++. When miss_cnt reaches LOST_FRAMES: go to IDLE, pulse lost_pulse,
//          queue update with en=0 (edges hold their last values).
//  Handshake: a queued update drives ovl_valid at T+2.
//   The payload stays stable while ovl_valid=1 and ovl_ready=0.
//   A transfer completes when valid&ready; ovl_valid drops the next cycle unless the shadow slot is full.
//  Simultaneous events: an update queued while ovl_valid=1 goes to a one-deep shadow slot.
//   A newer update overwrites the shadow slot and increments overrun_cnt (saturates at 255).
//   When the pending transfer completes, the shadow moves to the payload and ovl_valid stays high with no bubble.
//   When queue and accept land in the same cycle, the new update goes directly to the payload.
//  frame_done arriving while an evaluation is in flight (back-to-back frames): the new pulse is processed next.
//   The FSM handles at most one evaluation per cycle; no frames are lost.
// CONFIGURATION
//  BOX_SMOOTH_EN defined: while in TRACK, each queued edge is e_new = e_old + ((e_in - e_old) >>> SMOOTH_SHIFT).
//   The difference is signed 12-bit; the result is clamped to 0..2047.
//   On entry to TRACK from IDLE, the edges load raw with no smoothing.
//  BOX_SMOOTH_EN undefined: queued edges are the raw captured edges. There is no added latency in either case.
// STRUCTURE
//  Package box_pkg holds:
//   typedef coord_t (logic [10:0]) and the track_state_t enum {IDLE, TRACK, COAST}
//   localparams for the state encoding and COORD_W=11
//  Sub-module box_coord_filter: per-edge hit/size check plus the optional IIR.
//   It is instantiated once and is combinational or single-cycle.
//  The FSM, counters and the two-slot handshake stay in box_track_ctrl.
// TESTING
//  Reset: hold ovl_ready=1; send 3 hits (10,50,20,80) -> state=1 at T+1 of frame 3.
//   ovl_valid at T+2 with en=1 and edges 10/50/20/80; no update on frames 1-2.
//  Size reject: box 10..14 x 20..80 (height 5 < 8) for 5 frames -> state stays 0, ovl_valid never asserts.
//  Loss: in TRACK, send 4 misses -> state 2 after miss 1.
//   After miss 4: state 0, lost_pulse=1 for exactly one cycle, update with en=0.
//  Recover: in COAST after 2 misses, send a hit -> state 1, miss_cnt cleared.
//   Then 3 more misses do not drop the track.
//  Backpressure: ovl_ready=0, 3 tracked frames -> the first payload is held stable and overrun_cnt=1.
//   Release ready -> two back-to-back transfers; the second carries frame-3 edges.
//  BOX_SMOOTH_EN, SHIFT=2: in TRACK with top=100, input top=140 -> ovl_top=110; next frame at 140 -> 117.
//   Assert async reset mid-transfer -> ovl_valid=0 immediately.

Source files
------------

// File: rtl/box_pkg.sv
// box_pkg: shared coordinate, state and overlay payload types for the box tracker.
package box_pkg;
    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, COAST = 2'd2} track_state_t;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_COAST = 2'd2;
    typedef struct packed {
        logic        en;
        coord_t [3:0] e;
    } ovl_t;
endpackage

// File: rtl/box_coord_filter.sv
// box_coord_filter: box hit/size check plus optional IIR edge smoothing (BOX_SMOOTH_EN).
// Edge index order is 0=top 1=bottom 2=left 3=right.
module box_coord_filter import box_pkg::*; #(
    parameter int MIN_SIZE = 8
`ifdef BOX_SMOOTH_EN
    , parameter int SMOOTH_SHIFT = 2
`endif
) (
    input  logic         flag_i,
    input  coord_t [3:0] edge_i,
`ifdef BOX_SMOOTH_EN
    input  coord_t [3:0] old_i,
    input  logic         smooth_i,
`endif
    output logic         hit_o,
    output coord_t [3:0] edge_o
);
    logic [11:0] h, w;
    assign h = {1'b0, edge_i[1]} - {1'b0, edge_i[0]} + 12'd1;
    assign w = {1'b0, edge_i[3]} - {1'b0, edge_i[2]} + 12'd1;
    assign hit_o = flag_i && edge_i[1] >= edge_i[0] && edge_i[3] >= edge_i[2] &&
                   h >= 12'(MIN_SIZE) && w >= 12'(MIN_SIZE);
`ifdef BOX_SMOOTH_EN
    for (genvar i = 0; i < 4; i++) begin : g_e
        logic signed [12:0] d, s;
        assign d = $signed({2'b0, edge_i[i]}) - $signed({2'b0, old_i[i]});
        assign s = $signed({2'b0, old_i[i]}) + (d >>> SMOOTH_SHIFT);
        assign edge_o[i] = !smooth_i ? edge_i[i] : s[12] ? '0 : s[11] ? '1 : s[10:0];
    end
`else
    assign edge_o = edge_i;
`endif
endmodule

// File: rtl/box_track_ctrl.sv
// box_track_ctrl: per-frame hysteresis tracker pushing overlay updates over valid/ready.
// Optional edge smoothing while tracking is enabled by defining BOX_SMOOTH_EN.
module box_track_ctrl import box_pkg::*; #(
    parameter int ACQ_FRAMES   = 3,
    parameter int LOST_FRAMES  = 4,
    parameter int MIN_SIZE     = 8,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_done,
    input  logic         box_flag,
    input  logic [10:0]  top_edge,
    input  logic [10:0]  bottom_edge,
    input  logic [10:0]  left_edge,
    input  logic [10:0]  right_edge,
    output logic         ovl_valid,
    input  logic         ovl_ready,
    output logic         ovl_en,
    output logic [10:0]  ovl_top,
    output logic [10:0]  ovl_bottom,
    output logic [10:0]  ovl_left,
    output logic [10:0]  ovl_right,
    output logic [1:0]   track_state,
    output logic         lost_pulse,
    output logic [7:0]   overrun_cnt
);
    coord_t [3:0] cap_q, last_q, filt_e;
    logic         flag_q, eval_q, hit, lost_q, lost_d, q, q_en;
    logic [1:0]   state_q, state_d;
    logic [3:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic         valid_q, shd_v_q, acc;
    logic [7:0]   ovr_q;
    ovl_t         pay_q, shd_q, upd;

    box_coord_filter #(
        .MIN_SIZE(MIN_SIZE)
`ifdef BOX_SMOOTH_EN
        , .SMOOTH_SHIFT(SMOOTH_SHIFT)
`endif
    ) u_filt (
        .flag_i(flag_q),
        .edge_i(cap_q),
`ifdef BOX_SMOOTH_EN
        .old_i(last_q),
        .smooth_i(state_q == S_TRACK),
`endif
        .hit_o(hit),
        .edge_o(filt_e)
    );

    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        q          = 1'b0;
        q_en       = 1'b1;
        lost_d     = 1'b0;
        if (eval_q) begin
            case (state_q)
                S_IDLE: begin
                    hit_cnt_d = hit ? hit_cnt_q + 4'd1 : 4'd0;
                    if (hit && hit_cnt_q + 4'd1 == 4'(ACQ_FRAMES)) begin
                        state_d   = S_TRACK;
                        hit_cnt_d = 4'd0;
                        q         = 1'b1;
                    end
                end
                S_TRACK: begin
                    q          = hit;
                    state_d    = hit ? S_TRACK : S_COAST;
                    miss_cnt_d = hit ? miss_cnt_q : 4'd1;
                end
                S_COAST: begin
                    q          = hit;
                    state_d    = hit ? S_TRACK : S_COAST;
                    miss_cnt_d = hit ? 4'd0 : miss_cnt_q + 4'd1;
                    if (!hit && miss_cnt_q + 4'd1 == 4'(LOST_FRAMES)) begin
                        state_d    = S_IDLE;
                        miss_cnt_d = 4'd0;
                        lost_d     = 1'b1;
                        q          = 1'b1;
                        q_en       = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A loss update clears enable but keeps the last drawn box edges.
    assign upd = '{en: q_en, e: q_en ? filt_e : last_q};
    assign acc = valid_q && ovl_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q      <= '0;
            flag_q     <= 1'b0;
            eval_q     <= 1'b0;
            state_q    <= S_IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            lost_q     <= 1'b0;
            last_q     <= '0;
            valid_q    <= 1'b0;
            pay_q      <= '0;
            shd_v_q    <= 1'b0;
            shd_q      <= '0;
            ovr_q      <= '0;
        end else begin
            eval_q     <= frame_done;
            if (frame_done) begin
                flag_q <= box_flag;
                cap_q  <= {right_edge, left_edge, bottom_edge, top_edge};
            end
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            lost_q     <= lost_d;
            if (q) last_q <= upd.e;
            if (q && shd_v_q && ovr_q != 8'hff) ovr_q <= ovr_q + 8'd1;
            if (q && (!valid_q || acc)) begin
                pay_q   <= upd;
                valid_q <= 1'b1;
                shd_v_q <= 1'b0;
            end else if (q) begin
                shd_q   <= upd;
                shd_v_q <= 1'b1;
            end else if (acc) begin
                pay_q   <= shd_v_q ? shd_q : pay_q;
                valid_q <= shd_v_q;
                shd_v_q <= 1'b0;
            end
        end
    end

    assign ovl_valid   = valid_q;
    assign ovl_en      = pay_q.en;
    assign ovl_top     = pay_q.e[0];
    assign ovl_bottom  = pay_q.e[1];
    assign ovl_left    = pay_q.e[2];
    assign ovl_right   = pay_q.e[3];
    assign track_state = state_q;
    assign lost_pulse  = lost_q;
    assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_box_track_ctrl.sv
// tb_box_track_ctrl: scoreboard bench for box_track_ctrl (default build, smoothing off).
module tb_box_track_ctrl;
    logic        clk = 0, rst_n = 0, frame_done = 0, box_flag = 0, ovl_ready = 1;
    logic [10:0] top_edge = 0, bottom_edge = 0, left_edge = 0, right_edge = 0;
    logic        ovl_valid, ovl_en, lost_pulse;
    logic [10:0] ovl_top, ovl_bottom, ovl_left, ovl_right;
    logic [1:0]  track_state;
    logic [7:0]  overrun_cnt;
    int          total = 0, bad = 0;
    logic [44:0] sb[$];

    box_track_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_done(frame_done), .box_flag(box_flag),
        .top_edge(top_edge), .bottom_edge(bottom_edge), .left_edge(left_edge), .right_edge(right_edge),
        .ovl_valid(ovl_valid), .ovl_ready(ovl_ready), .ovl_en(ovl_en),
        .ovl_top(ovl_top), .ovl_bottom(ovl_bottom), .ovl_left(ovl_left), .ovl_right(ovl_right),
        .track_state(track_state), .lost_pulse(lost_pulse), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && ovl_valid && ovl_ready) begin
            logic [44:0] got, exp;
            got = {ovl_en, ovl_top, ovl_bottom, ovl_left, ovl_right};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_update got=%h required=none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL update got=%h required=%h", got, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input bit en, input int t, input int b, input int l, input int r);
        sb.push_back({en, 11'(t), 11'(b), 11'(l), 11'(r)});
    endtask

    task automatic frame(input bit f, input int t, input int b, input int l, input int r);
        @(posedge clk); #1;
        frame_done = 1; box_flag = f;
        top_edge = 11'(t); bottom_edge = 11'(b); left_edge = 11'(l); right_edge = 11'(r);
        @(posedge clk); #1;
        frame_done = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #3 frame_done = 1; box_flag = 1;
        top_edge = 10; bottom_edge = 50; left_edge = 20; right_edge = 80;
        repeat (2) @(posedge clk);
        #1 frame_done = 0;
        chk("rst_state", track_state, 0);
        chk("rst_valid", ovl_valid, 0);
        chk("rst_overrun", overrun_cnt, 0);
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("rst_ignore_fd", track_state, 0);

        frame(1, 10, 50, 20, 80);  chk("acq1", track_state, 0);
        frame(1, 10, 50, 20, 80);  chk("acq2", track_state, 0);
        push(1, 10, 50, 20, 80);
        frame(1, 10, 50, 20, 80);  chk("acq3", track_state, 1);
        push(1, 5, 100, 30, 200);
        frame(1, 5, 100, 30, 200); chk("track_hit", track_state, 1);

        frame(0, 0, 0, 0, 0);      chk("miss1", track_state, 2);
        frame(0, 0, 0, 0, 0);      chk("miss2", track_state, 2);
        frame(0, 0, 0, 0, 0);      chk("miss3", track_state, 2);
        push(0, 5, 100, 30, 200);
        frame(0, 0, 0, 0, 0);      chk("miss4", track_state, 0);
        chk("lost_pulse_on", lost_pulse, 1);
        @(posedge clk); #1 chk("lost_pulse_off", lost_pulse, 0);

        for (int i = 0; i < 5; i++) begin
            frame(1, 10, 14, 20, 80);
            chk("size_reject", track_state, 0);
        end

        frame(1, 10, 50, 20, 80);
        frame(1, 10, 50, 20, 80);
        push(1, 10, 50, 20, 80);
        frame(1, 10, 50, 20, 80);  chk("reacq", track_state, 1);
        frame(0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0);      chk("coast2", track_state, 2);
        push(1, 12, 60, 22, 90);
        frame(1, 12, 60, 22, 90);  chk("recover", track_state, 1);
        for (int i = 0; i < 3; i++) begin
            frame(0, 0, 0, 0, 0);
            chk("post_recover_miss", track_state, 2);
        end
        push(1, 12, 60, 22, 90);
        frame(1, 12, 60, 22, 90);  chk("retrack", track_state, 1);

        repeat (2) @(posedge clk);
        #1 ovl_ready = 0;
        push(1, 1, 20, 2, 30);
        frame(1, 1, 20, 2, 30);
        frame(1, 3, 40, 4, 50);
        push(1, 5, 60, 6, 70);
        frame(1, 5, 60, 6, 70);
        chk("bp_valid", ovl_valid, 1);
        chk("bp_hold_top", ovl_top, 1);
        chk("bp_overrun", overrun_cnt, 1);
        ovl_ready = 1;
        @(posedge clk); #1;
        chk("bp_no_bubble", ovl_valid, 1);
        chk("bp_second_top", ovl_top, 5);
        @(posedge clk); #1 chk("bp_drained", ovl_valid, 0);

        push(1, 7, 77, 8, 88);
        push(1, 9, 99, 10, 110);
        @(posedge clk); #1;
        frame_done = 1; box_flag = 1;
        top_edge = 7; bottom_edge = 77; left_edge = 8; right_edge = 88;
        @(posedge clk); #1;
        top_edge = 9; bottom_edge = 99; left_edge = 10; right_edge = 110;
        @(posedge clk); #1 frame_done = 0;

        begin
            int n = 0;
            while (sb.size() != 0 && n < 50) begin
                @(posedge clk); n++;
            end
            chk("sb_drained", sb.size(), 0);
        end

        ovl_ready = 0;
        frame(1, 1, 20, 2, 30);
        chk("pre_rst_valid", ovl_valid, 1);
        #2 rst_n = 0;
        #1 chk("async_rst_valid", ovl_valid, 0);
        chk("async_rst_state", track_state, 0);
        #10 rst_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1);
    end
endmodule
